// File: rtl/updown_mod_counter.sv
// Synchronous parametrised up/down modulo counter with parallel load, prescaled
// count enable, wrap/saturate boundary mode, terminal-count and wrap-event flags.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
);

    localparam int unsigned PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);
    localparam logic [PCW-1:0]   PC_MAX = PCW'(PRESCALE - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [PCW-1:0]   pc_q, pc_d;
    logic             wrap_q, wrap_d;
    logic             tick;

    // With PRESCALE=1, PC_MAX is 0 and pc stays 0, so tick collapses to en.
    assign tick = en && (pc_q == PC_MAX);

    always_comb begin
        q_d    = q_q;
        pc_d   = pc_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d  = (load_val > MAX_Q) ? MAX_Q : load_val;
            pc_d = '0;
        end else if (en) begin
            pc_d = tick ? '0 : pc_q + 1'b1;
            if (tick) begin
                if (up) begin
                    if (q_q != MAX_Q) begin
                        q_d = q_q + 1'b1;
                    end else if (!sat) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    if (q_q != '0) begin
                        q_d = q_q - 1'b1;
                    end else if (!sat) begin
                        q_d    = MAX_Q;
                        wrap_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            pc_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;
    assign wrap  = wrap_q;
    assign tc    = up ? (q_q == MAX_Q) : (q_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: dut_a is mod-10 with no prescale, dut_b is mod-16 prescaled by 3;
// both share the same input stimulus.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, sat, load;
    logic [3:0] load_val;
    logic [3:0] qa, qa_bar, qb, qb_bar;
    logic       tc_a, wrap_a, tc_b, wrap_b;

    int checks   = 0;
    int failures = 0;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .q(qa), .q_bar(qa_bar), .tc(tc_a), .wrap(wrap_a)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .q(qb), .q_bar(qb_bar), .tc(tc_b), .wrap(wrap_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; up = 1'b0; sat = 1'b0; load = 1'b0; load_val = 4'd0;
        step();
        step();
        checks++; if (qa !== 4'd0)     begin failures++; $display("FAIL reset_qa got=%0h exp=0", qa); end
        checks++; if (qa_bar !== 4'hF) begin failures++; $display("FAIL reset_qbar got=%0h exp=f", qa_bar); end
        checks++; if (wrap_a !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%0b exp=0", wrap_a); end
        checks++; if (tc_a !== 1'b1)   begin failures++; $display("FAIL reset_tc got=%0b exp=1", tc_a); end
        checks++; if (qb !== 4'd0)     begin failures++; $display("FAIL reset_qb got=%0h exp=0", qb); end
        rst = 1'b0;
    endtask

    task automatic test_up_wrap();
        int exp;
        do_reset();
        sat = 1'b0; up = 1'b1; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            exp = (i + 1) % 10;
            checks++; if (qa !== 4'(exp)) begin failures++; $display("FAIL upwrap_q[%0d] got=%0d exp=%0d", i, qa, exp); end
            checks++; if (wrap_a !== (i == 9)) begin failures++; $display("FAIL upwrap_wrap[%0d] got=%0b exp=%0b", i, wrap_a, i == 9); end
            checks++; if (tc_a !== (exp == 9)) begin failures++; $display("FAIL upwrap_tc[%0d] got=%0b exp=%0b", i, tc_a, exp == 9); end
        end
    endtask

    task automatic test_down_sat();
        int exp_q[6] = '{2, 1, 0, 0, 0, 0};
        do_reset();
        load = 1'b1; load_val = 4'd3; en = 1'b0;
        step();
        load = 1'b0;
        checks++; if (qa !== 4'd3) begin failures++; $display("FAIL dsat_load got=%0d exp=3", qa); end
        sat = 1'b1; up = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (qa !== 4'(exp_q[i])) begin failures++; $display("FAIL dsat_q[%0d] got=%0d exp=%0d", i, qa, exp_q[i]); end
            checks++; if (wrap_a !== 1'b0) begin failures++; $display("FAIL dsat_wrap[%0d] got=%0b exp=0", i, wrap_a); end
            checks++; if (tc_a !== (exp_q[i] == 0)) begin failures++; $display("FAIL dsat_tc[%0d] got=%0b exp=%0b", i, tc_a, exp_q[i] == 0); end
        end
        sat = 1'b0;
    endtask

    task automatic test_down_wrap();
        do_reset();
        up = 1'b0; sat = 1'b0; en = 1'b1;
        step();
        checks++; if (qa !== 4'd9)     begin failures++; $display("FAIL dwrap_q got=%0d exp=9", qa); end
        checks++; if (wrap_a !== 1'b1) begin failures++; $display("FAIL dwrap_wrap got=%0b exp=1", wrap_a); end
        step();
        checks++; if (qa !== 4'd8)     begin failures++; $display("FAIL dwrap_q2 got=%0d exp=8", qa); end
        checks++; if (wrap_a !== 1'b0) begin failures++; $display("FAIL dwrap_wrap2 got=%0b exp=0", wrap_a); end
    endtask

    task automatic test_prescale();
        logic en_seq[7] = '{1, 1, 0, 1, 1, 1, 1};
        int   exp_q[7]  = '{0, 0, 0, 1, 1, 1, 2};
        do_reset();
        up = 1'b1; sat = 1'b0;
        for (int i = 0; i < 7; i++) begin
            en = en_seq[i];
            step();
            checks++; if (qb !== 4'(exp_q[i])) begin failures++; $display("FAIL presc_q[%0d] got=%0d exp=%0d", i, qb, exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_prescale();
        int exp_q[3] = '{0, 0, 1};
        do_reset();
        up = 1'b1; en = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (qb !== 4'(exp_q[i])) begin failures++; $display("FAIL rstpc_q[%0d] got=%0d exp=%0d", i, qb, exp_q[i]); end
        end
    endtask

    task automatic test_load_clamp();
        int exp_qb[3] = '{13, 13, 14};
        do_reset();
        up = 1'b1; sat = 1'b0; en = 1'b1;
        step();
        load = 1'b1; load_val = 4'd13;
        step();
        load = 1'b0;
        checks++; if (qa !== 4'd9)  begin failures++; $display("FAIL clamp_qa got=%0d exp=9", qa); end
        checks++; if (qb !== 4'd13) begin failures++; $display("FAIL clamp_qb got=%0d exp=13", qb); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (qb !== 4'(exp_qb[i])) begin failures++; $display("FAIL loadpc_q[%0d] got=%0d exp=%0d", i, qb, exp_qb[i]); end
        end
        rst = 1'b1; load = 1'b1; load_val = 4'd5;
        step();
        rst = 1'b0; load = 1'b0;
        checks++; if (qa !== 4'd0) begin failures++; $display("FAIL rstload_qa got=%0d exp=0", qa); end
        checks++; if (qb !== 4'd0) begin failures++; $display("FAIL rstload_qb got=%0d exp=0", qb); end
    endtask

    task automatic test_dir_flip();
        do_reset();
        up = 1'b1; sat = 1'b0; en = 1'b0;
        load = 1'b1; load_val = 4'd9;
        step();
        load = 1'b0;
        checks++; if (tc_a !== 1'b1) begin failures++; $display("FAIL flip_tc_up got=%0b exp=1", tc_a); end
        up = 1'b0;
        #1;
        checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL flip_tc_dn got=%0b exp=0", tc_a); end
        en = 1'b1;
        step();
        checks++; if (qa !== 4'd8)     begin failures++; $display("FAIL flip_q got=%0d exp=8", qa); end
        checks++; if (wrap_a !== 1'b0) begin failures++; $display("FAIL flip_wrap got=%0b exp=0", wrap_a); end
        checks++; if (qa_bar !== 4'h7) begin failures++; $display("FAIL flip_qbar got=%0h exp=7", qa_bar); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b0; sat = 1'b0; load = 1'b0; load_val = 4'd0;
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_down_wrap();
        test_prescale();
        test_reset_mid_prescale();
        test_load_clamp();
        test_dir_flip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
